bus_rr_arb: RTL

Parametrised successor to the single-host system bus: connects `NrHosts` memory hosts (Ibex data port, DMA, debug) to `NrDevices` memory-mapped slaves (RAM, simulator control, timer, …) with round-robin arbitration and address decode. Unmapped accesses get an error response instead of hanging. It sits between the core/host ports and the device ports in the simple system top level.

---
 rtl/bus_rr_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bus_rr_arb.sv
// rtl/bus_rr_arb.sv - round-robin multi-host bus with address decode and error responses
// Optional feature: define BUS_RR_ERR_CNT_EN to enable the decode-error counter on err_count_o.
module bus_rr_arb #(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 3,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NrHosts-1:0]                      host_req_i,
  output logic [NrHosts-1:0]                      host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                      host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
  output logic [NrHosts-1:0]                      host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
  output logic [NrHosts-1:0]                      host_err_o,
  output logic [NrDevices-1:0]                    device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]  device_addr_o,
  output logic [NrDevices-1:0]                    device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]   device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]     device_wdata_o,
  input  logic [NrDevices-1:0]                    device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata_i,
  input  logic [NrDevices-1:0]                    device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_mask,
  output logic [15:0]                             err_count_o
);

  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic [HostIdxW-1:0]     prio;
  logic                    gnt_any;
  logic [HostIdxW-1:0]     gnt_idx;
  logic [AddressWidth-1:0] gnt_addr;
  logic                    dev_hit;
  logic [DevIdxW-1:0]      dev_idx;

  logic                    pend_valid;
  logic [HostIdxW-1:0]     pend_host;
  logic [DevIdxW-1:0]      pend_dev;
  logic                    pend_err;

  // Responses are trusted to arrive one cycle after the request, so device rvalid carries no information.
  logic [NrDevices-1:0]    unused_device_rvalid;
  assign unused_device_rvalid = device_rvalid_i;

  always_comb begin
    logic [HostIdxW-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NrHosts; k++) begin
      cand = HostIdxW'((int'(prio) + k) % NrHosts);
      if (!gnt_any && host_req_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_addr = host_addr_i[gnt_idx];

  // Scanning downwards lets the lowest matching device index overwrite any higher match.
  always_comb begin
    dev_hit = 1'b0;
    dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((gnt_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dev_hit = 1'b1;
        dev_idx = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    host_gnt_o     = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (gnt_any) begin
      host_gnt_o[gnt_idx] = 1'b1;
      if (dev_hit) begin
        device_req_o[dev_idx]   = 1'b1;
        device_addr_o[dev_idx]  = gnt_addr;
        device_we_o[dev_idx]    = host_we_i[gnt_idx];
        device_be_o[dev_idx]    = host_be_i[gnt_idx];
        device_wdata_o[dev_idx] = host_wdata_i[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio       <= '0;
      pend_valid <= 1'b0;
      pend_host  <= '0;
      pend_dev   <= '0;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= gnt_any;
      if (gnt_any) begin
        pend_host <= gnt_idx;
        pend_dev  <= dev_idx;
        pend_err  <= ~dev_hit;
        prio      <= (gnt_idx == HostIdxW'(NrHosts - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    if (pend_valid) begin
      host_rvalid_o[pend_host] = 1'b1;
      if (pend_err) begin
        host_err_o[pend_host] = 1'b1;
      end else begin
        host_rdata_o[pend_host] = device_rdata_i[pend_dev];
        host_err_o[pend_host]   = device_err_i[pend_dev];
      end
    end
  end

`ifdef BUS_RR_ERR_CNT_EN
  logic [15:0] err_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_count <= '0;
    end else if (gnt_any && !dev_hit && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign err_count_o = err_count;
`else
  assign err_count_o = 16'h0;
`endif

endmodule
